mux_serializer: RTL and testbench

Parallel-to-serial gather stage: accepts one frame of S lanes of N-bit coefficients (the same lane packing the scatter demux produces) and emits them one lane per cycle over a valid/ready stream, lane 0 first. It sits at the output of the NTT butterfly bank and feeds the single-port coefficient memory write path. Back-to-back frames stream with no bubble when the consumer never stalls.

---
 rtl/mux_serializer_pkg.sv | 8 +
 rtl/mux_serializer_mux_nx1.sv | 27 ++
 rtl/mux_serializer.sv | 93 +++++++++
 tb/tb_mux_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_serializer_pkg.sv
// Shared constants for the gather (parallel-to-serial) stage.
package mux_serializer_pkg;

  // FSM encodings kept as plain constants for compatibility with older tooling.
  localparam logic [0:0] ST_IDLE  = 1'b0;  // no frame held
  localparam logic [0:0] ST_SHIFT = 1'b1;  // frame held, lanes being emitted

endpackage

// File: rtl/mux_serializer_mux_nx1.sv
// Combinational LANES-to-1 lane selector.
// Lane k lives at bits [(k+1)*N-1 : k*N], the same packing the scatter demux
// produces, so selecting index k returns exactly what was scattered to lane k.
module mux_nx1 #(
  parameter int N = 16,
  parameter int S = 4
) (
  input  logic [(2**$clog2(S))*N-1:0] data,
  input  logic [$clog2(S)-1:0]        sel,
  output logic [N-1:0]                y
);

  localparam int SEL_W = $clog2(S);
  localparam int LANES = 2**SEL_W;

  logic [N-1:0] lanes [LANES];

  // Unpack the flat bus into an array so the select is a plain index.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lanes[gi] = data[gi*N +: N];
    end
  endgenerate

  assign y = lanes[sel];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial gather stage: takes one frame of S lanes and streams them
// out one lane per cycle, lane 0 first, over a valid/ready interface.
// A new frame can be taken on the same edge the last lane leaves, so frames
// stream back-to-back without a bubble when the consumer never stalls.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int N = 16,
  parameter int S = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(2**$clog2(S))*N-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                out_data,
  output logic [$clog2(S)-1:0]        out_sel,
  output logic                        out_last
);

  localparam int SEL_W = $clog2(S);
  localparam int LANES = 2**SEL_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(S - 1);

  logic [0:0]         state;
  logic [LANES*N-1:0] frame_q;
  logic [SEL_W-1:0]   sel_q;

  logic in_hs;
  logic out_hs;

  // Output flags decode from state and the lane counter; in_ready only adds
  // the out_ready path so a new frame can overlap the final beat.
  always_comb begin
    out_valid = (state == ST_SHIFT);
    out_last  = out_valid && (sel_q == LAST_SEL);
    out_sel   = sel_q;
    in_ready  = (state == ST_IDLE) || (out_ready && out_last);
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
  end

  // Lane selector: in IDLE sel_q is 0, so out_data shows lane 0 of frame_q.
  mux_nx1 #(
    .N (N),
    .S (S)
  ) u_mux (
    .data (frame_q),
    .sel  (sel_q),
    .y    (out_data)
  );

  // FSM, lane counter and frame register. Padding lanes (index >= S) are
  // stored but sel_q wraps at S-1, so they are never emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel_q   <= '0;
      frame_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_hs) begin
            frame_q <= in_data;
            sel_q   <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (out_hs) begin
            if (out_last) begin
              sel_q <= '0;
              if (in_hs) begin
                frame_q <= in_data;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          sel_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Self-checking bench for mux_serializer: one S=4/N=16 instance and one
// S=3/N=8 instance. Expected lanes are pushed on every input handshake and
// popped/compared on every output handshake.
module tb_mux_serializer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Instance A: N=16, S=4
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [63:0] a_in_data;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_sel;

  // Instance B: N=8, S=3 (bus padded to 4 lanes)
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_in_data;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_sel;

  mux_serializer #(.N(16), .S(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel),
    .out_last  (a_out_last)
  );

  mux_serializer #(.N(8), .S(3)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel),
    .out_last  (b_out_last)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  sel;
    logic        last;
  } item_t;

  item_t a_q[$];
  item_t b_q[$];

  int total = 0;
  int bad   = 0;
  int a_pops = 0;
  int b_pops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven (at the falling edge); sample
  // handshakes just after, update the scoreboard, then advance to the next
  // falling edge.
  task automatic tick();
    item_t it;
    #1;
    if (a_in_valid && a_in_ready) begin
      for (int k = 0; k < 4; k++) begin
        it.data = a_in_data[k*16 +: 16];
        it.sel  = 2'(k);
        it.last = (k == 3);
        a_q.push_back(it);
      end
    end
    if (b_in_valid && b_in_ready) begin
      for (int k = 0; k < 3; k++) begin
        it.data = {8'h00, b_in_data[k*8 +: 8]};
        it.sel  = 2'(k);
        it.last = (k == 2);
        b_q.push_back(it);
      end
    end
    if (a_out_valid && a_out_ready) begin
      a_pops++;
      if (a_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL A.unexpected_beat observed=%0h expected=none", a_out_data);
      end else begin
        it = a_q.pop_front();
        chk("A.data", 32'(a_out_data), 32'(it.data));
        chk("A.sel",  32'(a_out_sel),  32'(it.sel));
        chk("A.last", 32'(a_out_last), 32'(it.last));
      end
    end
    if (b_out_valid && b_out_ready) begin
      b_pops++;
      if (b_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL B.unexpected_beat observed=%0h expected=none", b_out_data);
      end else begin
        it = b_q.pop_front();
        chk("B.data", 32'(b_out_data), 32'(it.data[7:0]));
        chk("B.sel",  32'(b_out_sel),  32'(it.sel));
        chk("B.last", 32'(b_out_last), 32'(it.last));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0;

    // Reset state
    @(negedge clk);
    chk("rst.a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst.a_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst.a_out_sel",   32'(a_out_sel),   32'd0);
    chk("rst.a_out_last",  32'(a_out_last),  32'd0);
    chk("rst.a_out_data",  32'(a_out_data),  32'd0);
    chk("rst.b_out_valid", 32'(b_out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset checked");

    // Single frame
    a_in_valid = 1'b1;
    a_in_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick();
    a_in_valid = 1'b0;
    a_pops = 0;
    for (int i = 0; i < 4; i++) begin
      chk("single.out_valid", 32'(a_out_valid), 32'd1);
      tick();
    end
    chk("single.pops", 32'(a_pops), 32'd4);
    chk("single.idle_valid", 32'(a_out_valid), 32'd0);
    chk("single.sb_empty", 32'(a_q.size()), 32'd0);
    $display("single frame: beats=%0d", a_pops);

    // Back-to-back frames A then B
    a_in_valid = 1'b1;
    a_in_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    tick();
    a_in_data  = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    a_pops = 0;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = (i <= 3);
      #1;
      chk("b2b.out_valid", 32'(a_out_valid), 32'd1);
      if (i <= 3) chk("b2b.in_ready", 32'(a_in_ready), 32'(i == 3));
      tick();
    end
    a_in_valid = 1'b0;
    chk("b2b.pops", 32'(a_pops), 32'd8);
    chk("b2b.idle_valid", 32'(a_out_valid), 32'd0);
    $display("back-to-back: beats=%0d", a_pops);

    // Backpressure on lane 1
    a_in_valid = 1'b1;
    a_in_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick();
    a_in_valid = 1'b0;
    tick();                                   // lane 0 leaves
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.out_data",  32'(a_out_data), 32'h2222);
      chk("bp.out_sel",   32'(a_out_sel),  32'd1);
      chk("bp.in_ready",  32'(a_in_ready), 32'd0);
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("bp.idle_valid", 32'(a_out_valid), 32'd0);
    chk("bp.sb_empty", 32'(a_q.size()), 32'd0);
    $display("backpressure checked");

    // Last-beat stall: new frame waits until out_ready rises
    a_in_valid = 1'b1;
    a_in_data  = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall.in_ready", 32'(a_in_ready), 32'd0);
      chk("stall.out_last", 32'(a_out_last), 32'd1);
      chk("stall.out_data", 32'(a_out_data), 32'hC003);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("stall.in_ready_rise", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall.sb_empty", 32'(a_q.size()), 32'd0);
    chk("stall.idle_valid", 32'(a_out_valid), 32'd0);
    $display("last-beat stall checked");

    // Reset mid-frame (sel_q = 2)
    a_in_valid = 1'b1;
    a_in_data  = {16'hE003, 16'hE002, 16'hE001, 16'hE000};
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    chk("midrst.pre_sel", 32'(a_out_sel), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(a_out_valid), 32'd0);
    chk("midrst.in_ready",  32'(a_in_ready),  32'd1);
    chk("midrst.out_sel",   32'(a_out_sel),   32'd0);
    a_q.delete();
    b_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_data  = {16'hF003, 16'hF002, 16'hF001, 16'hF000};
    tick();
    a_in_valid = 1'b0;
    a_pops = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst.pops", 32'(a_pops), 32'd4);
    chk("midrst.sb_empty", 32'(a_q.size()), 32'd0);
    $display("mid-frame reset checked");

    // Non-power-of-two: S=3, N=8, padding lane never emitted
    b_in_valid = 1'b1;
    b_in_data  = 32'hDD_CC_BB_AA;
    tick();
    b_in_data  = 32'h44_33_22_11;
    b_pops = 0;
    for (int i = 0; i < 6; i++) begin
      b_in_valid = (i <= 2);
      #1;
      chk("np2.out_valid", 32'(b_out_valid), 32'd1);
      if (b_out_data === 8'hDD || b_out_data === 8'h44) chk("np2.pad_lane", 32'(b_out_data), 32'd0);
      tick();
    end
    b_in_valid = 1'b0;
    chk("np2.pops", 32'(b_pops), 32'd6);
    chk("np2.idle_valid", 32'(b_out_valid), 32'd0);
    chk("np2.sb_empty", 32'(b_q.size()), 32'd0);
    $display("non-power-of-two: beats=%0d", b_pops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
